// File: rtl/mac_nbit_pkg.sv
// rtl/mac_nbit_pkg.sv - shared FSM state type and width derivations for the MAC burst engine
package mac_nbit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_DRAIN = 2'd2
  } mac_state_e;

  function automatic int mac_acc_w(input int data_w, input int guard_w);
    return 2 * data_w + guard_w;
  endfunction

  function automatic int mac_sel_w(input int data_w, input int guard_w);
    return $clog2(mac_acc_w(data_w, guard_w) - data_w + 1);
  endfunction

endpackage

// File: rtl/mac_nbit_sat.sv
// rtl/mac_nbit_sat.sv - output window select and optional saturation of the final accumulator
module mac_nbit_sat
  import mac_nbit_pkg::*;
#(
  parameter int  DATA_W  = 8,
  parameter int  GUARD_W = 4,
  localparam int ACC_W   = mac_acc_w(DATA_W, GUARD_W),
  localparam int SEL_W   = mac_sel_w(DATA_W, GUARD_W)
) (
  input  logic [ACC_W-1:0]  acc_i,
  input  logic [SEL_W-1:0]  sel_i,
  input  logic              tc_i,
  input  logic              sat_en_i,
  output logic [DATA_W-1:0] data_o,
  output logic              sat_o
);

  logic [31:0]       hi_sh;
  logic [ACC_W-1:0]  hi_u;
  logic [ACC_W-1:0]  hi_s;
  logic [DATA_W-1:0] win;
  logic              ovf;

  assign hi_sh = 32'(sel_i) + 32'(DATA_W);
  assign win   = DATA_W'(acc_i >> sel_i);
  assign hi_u  = acc_i >> hi_sh;
  // Arithmetic shift keeps the sign bit, so all-equal upper bits collapse to all-0 or all-1
  assign hi_s  = $signed(acc_i) >>> (hi_sh - 32'd1);
  assign ovf   = tc_i ? !((&hi_s) || (~|hi_s)) : (|hi_u);

  always_comb begin
    data_o = win;
    sat_o  = 1'b0;
    if (sat_en_i && ovf) begin
      sat_o = 1'b1;
      if (!tc_i)
        data_o = '1;
      else if (acc_i[ACC_W-1])
        data_o = {1'b1, {(DATA_W-1){1'b0}}};
      else
        data_o = {1'b0, {(DATA_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/mac_nbit_pipe.sv
// rtl/mac_nbit_pipe.sv - burst multiply-accumulate with 3-stage pipeline and windowed output
module mac_nbit_pipe
  import mac_nbit_pkg::*;
#(
  parameter int  DATA_W  = 8,
  parameter int  GUARD_W = 4,
  parameter int  CNT_W   = 8,
  localparam int ACC_W   = mac_acc_w(DATA_W, GUARD_W),
  localparam int SEL_W   = mac_sel_w(DATA_W, GUARD_W)
) (
  input  logic              MAC_ACC_CLK,
  input  logic              acc_ff_rstn,
  input  logic              start,
  input  logic [CNT_W-1:0]  MAC_BURST_LEN,
  input  logic              MAC_TC,
  input  logic              MAC_ACC_RND,
  input  logic              MAC_ACC_SAT,
  input  logic [SEL_W-1:0]  MAC_OUT_SEL,
  input  logic              MAC_ACC_CLEAR,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] MAC_OPER_DATA,
  input  logic [DATA_W-1:0] MAC_COEF_DATA,
  output logic [DATA_W-1:0] MAC_OUT,
  output logic              out_valid,
  output logic              out_sat,
  output logic              busy
);

  localparam int SEL_MAX = ACC_W - DATA_W;

  mac_state_e          state_q;
  logic [CNT_W-1:0]    cnt_q, len_q;
  logic                tc_q, rnd_q, sat_q;
  logic [SEL_W-1:0]    sel_q;

  logic [DATA_W-1:0]   s1_a_q, s1_b_q;
  logic                s1_v_q, s1_last_q;
  logic [2*DATA_W-1:0] s2_prod_q, prod_d;
  logic                s2_v_q, s2_last_q;
  logic [ACC_W-1:0]    acc_q, prod_ext, seed;
  logic                acc_v_q;

  logic [DATA_W-1:0]   out_q, win_data;
  logic                out_valid_q, out_sat_q, win_sat;

  logic [SEL_W-1:0]    sel_in_eff;
  logic [2*DATA_W-1:0] a_ext, b_ext;
  logic                accept, last_accept, start_ok;

  assign in_ready    = (state_q == ST_ACC);
  assign busy        = (state_q != ST_IDLE);
  assign accept      = in_valid && in_ready;
  assign last_accept = accept && (cnt_q == len_q - CNT_W'(1));
  assign start_ok    = (state_q == ST_IDLE) && start && (MAC_BURST_LEN != '0);

  assign sel_in_eff  = (32'(MAC_OUT_SEL) > 32'(SEL_MAX)) ? '0 : MAC_OUT_SEL;
  // Rounding seed puts a half-LSB of the output window into the accumulator up front
  assign seed        = (MAC_ACC_RND && (sel_in_eff != '0)) ?
                       ({{(ACC_W-1){1'b0}}, 1'b1} << (sel_in_eff - SEL_W'(1))) : '0;

  assign a_ext    = tc_q ? {{DATA_W{s1_a_q[DATA_W-1]}}, s1_a_q} : {{DATA_W{1'b0}}, s1_a_q};
  assign b_ext    = tc_q ? {{DATA_W{s1_b_q[DATA_W-1]}}, s1_b_q} : {{DATA_W{1'b0}}, s1_b_q};
  assign prod_d   = a_ext * b_ext;
  assign prod_ext = tc_q ? {{GUARD_W{s2_prod_q[2*DATA_W-1]}}, s2_prod_q}
                         : {{GUARD_W{1'b0}}, s2_prod_q};

  always_ff @(posedge MAC_ACC_CLK or negedge acc_ff_rstn) begin
    if (!acc_ff_rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      tc_q    <= 1'b0;
      rnd_q   <= 1'b0;
      sat_q   <= 1'b0;
      sel_q   <= '0;
    end else if (MAC_ACC_CLEAR) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_ok) begin
            state_q <= ST_ACC;
            cnt_q   <= '0;
            len_q   <= MAC_BURST_LEN;
            tc_q    <= MAC_TC;
            rnd_q   <= MAC_ACC_RND;
            sat_q   <= MAC_ACC_SAT;
            sel_q   <= sel_in_eff;
          end
        end
        ST_ACC: begin
          if (accept) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_accept)
              state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (acc_v_q)
            state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge MAC_ACC_CLK or negedge acc_ff_rstn) begin
    if (!acc_ff_rstn) begin
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_v_q      <= 1'b0;
      s1_last_q   <= 1'b0;
      s2_prod_q   <= '0;
      s2_v_q      <= 1'b0;
      s2_last_q   <= 1'b0;
      acc_q       <= '0;
      acc_v_q     <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_sat_q   <= 1'b0;
    end else if (MAC_ACC_CLEAR) begin
      s1_v_q      <= 1'b0;
      s1_last_q   <= 1'b0;
      s2_v_q      <= 1'b0;
      s2_last_q   <= 1'b0;
      acc_q       <= '0;
      acc_v_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s1_v_q    <= accept;
      s1_last_q <= last_accept;
      if (accept) begin
        s1_a_q <= MAC_OPER_DATA;
        s1_b_q <= MAC_COEF_DATA;
      end
      s2_v_q    <= s1_v_q;
      s2_last_q <= s1_v_q && s1_last_q;
      if (s1_v_q)
        s2_prod_q <= prod_d;
      if (start_ok)
        acc_q <= seed;
      else if (s2_v_q)
        acc_q <= acc_q + prod_ext;
      // acc_v_q marks the cycle where acc_q holds the completed burst sum
      acc_v_q     <= s2_v_q && s2_last_q;
      out_valid_q <= acc_v_q;
      if (acc_v_q) begin
        out_q     <= win_data;
        out_sat_q <= win_sat;
      end
    end
  end

  mac_nbit_sat #(
    .DATA_W  (DATA_W),
    .GUARD_W (GUARD_W)
  ) u_sat (
    .acc_i    (acc_q),
    .sel_i    (sel_q),
    .tc_i     (tc_q),
    .sat_en_i (sat_q),
    .data_o   (win_data),
    .sat_o    (win_sat)
  );

  assign MAC_OUT   = out_q;
  assign out_valid = out_valid_q;
  assign out_sat   = out_sat_q;

  logic unused_rnd;
  assign unused_rnd = rnd_q;

endmodule

// File: doc/mac_nbit_pipe.md
MAC_NBIT_PIPE -- requirements
Module: mac_nbit_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 8, giving the operand and output width.
REQ-002 SHALL have parameter GUARD_W, default 4, giving the accumulator guard bits; ACC_W = 2*DATA_W+GUARD_W.
REQ-003 SHALL have parameter CNT_W, default 8, giving the burst-length width.
REQ-004 SHALL derive SEL_W = $clog2(ACC_W-DATA_W+1).
REQ-005 SHALL use reset acc_ff_rstn, asynchronous, active-low; clock MAC_ACC_CLK.
REQ-006 MAC_ACC_CLK  in  1  clock.
REQ-007 acc_ff_rstn  in  1  asynchronous active-low reset.
REQ-008 start  in  1  begin a burst; configuration is latched on start.
REQ-009 MAC_BURST_LEN  in  CNT_W  number of products per burst.
REQ-010 MAC_TC  in  1  1 = two's-complement operands, 0 = unsigned.
REQ-011 MAC_ACC_RND  in  1  enable round-half-up at the output window.
REQ-012 MAC_ACC_SAT  in  1  enable output saturation.
REQ-013 MAC_OUT_SEL  in  SEL_W  output window LSB position.
REQ-014 MAC_ACC_CLEAR  in  1  synchronous abort.
REQ-015 in_valid  in  1  operand pair valid.
REQ-016 in_ready  out  1  high only in state ACC.
REQ-017 MAC_OPER_DATA, MAC_COEF_DATA  in  DATA_W each  operands.
REQ-018 MAC_OUT  out  DATA_W  registered result.
REQ-019 out_valid  out  1  one-cycle result strobe.
REQ-020 out_sat  out  1  result was clamped; qualified by out_valid.
REQ-021 busy  out  1  state != IDLE.

Function
REQ-022 FSM SHALL have states IDLE, ACC and DRAIN.
- IDLE->ACC on start && MAC_BURST_LEN!=0.
- ACC->DRAIN when the last element is accepted.
- DRAIN->IDLE on the edge that sets out_valid.
REQ-023 start SHALL be ignored when MAC_BURST_LEN==0 or when not in IDLE.
REQ-024 On start, MAC_TC, RND, SAT, OUT_SEL and LEN SHALL be latched and held for the whole burst.
REQ-025 Acceptance SHALL be in_valid && in_ready. Each acceptance SHALL increment the element counter. Gaps in in_valid SHALL not affect the result.
REQ-026 The pipeline SHALL have stage 1 (operand register), stage 2 (registered full-precision product) and stage 3 (accumulator). Each stage SHALL carry its own valid bit.
REQ-027 If the last element is accepted in cycle L, out_valid SHALL be high in cycle L+4 only. MAC_OUT SHALL hold its value until the next out_valid.
REQ-028 Operands SHALL be sign-extended when TC=1 and zero-extended otherwise. Products SHALL be sign-extended or zero-extended to ACC_W. Accumulation SHALL wrap modulo 2^ACC_W.
REQ-029 The accumulator SHALL be seeded at start: (1<<(SEL-1)) if RND && SEL>0, else 0.
REQ-030 MAC_OUT SHALL be acc[SEL+DATA_W-1:SEL].
REQ-031 Window selection and saturation SHALL be computed from the final accumulator value.
REQ-032 Saturation (SAT=1) SHALL apply when acc[ACC_W-1:SEL+DATA_W-1] is not all-equal (TC=1), or when acc[ACC_W-1:SEL+DATA_W] is nonzero (TC=0).
- Unsigned clamp = all ones.
- Signed clamp = 0x80..0 if acc MSB=1, else 0x7F..F.
- out_sat=1 on clamp.
REQ-033 With SAT=0, out_sat SHALL be 0 and MAC_OUT SHALL be the raw window.
REQ-034 MAC_ACC_CLEAR SHALL return the FSM to IDLE at the next edge, zero the accumulator and all valid bits, and suppress out_valid. Clear SHALL win over a simultaneous start or acceptance.
REQ-035 MAC_OUT_SEL > ACC_W-DATA_W SHALL be treated as 0.

Reset
REQ-036 Reset SHALL force state IDLE and zero the accumulator, the counter, all pipeline registers and valid bits, and the latched configuration.
REQ-037 During reset, MAC_OUT=0, out_valid=0, out_sat=0, busy=0 and in_ready=0.
REQ-038 Reset asserted mid-burst SHALL discard the burst; no out_valid SHALL follow deassertion.

Structure
REQ-039 Package mac_nbit_pkg SHALL hold the FSM state enum and the SEL_W/ACC_W derivation constants.
REQ-040 Window select and saturation SHALL be a combinational sub-module, mac_nbit_sat.

Verification (DATA_W=8, GUARD_W=4)
REQ-041 TC=0, LEN=4, four products of 3*5, SEL=0 -> MAC_OUT=0x3C, out_sat=0, out_valid in L+4 only.
REQ-042 TC=1, LEN=2, (-128)*(-128) twice, SEL=0:
- SAT=1 -> MAC_OUT=0x7F, out_sat=1.
- SAT=0 -> MAC_OUT=0x00, out_sat=0.
REQ-043 TC=0, LEN=1, 7*1, SEL=1:
- RND=1 -> MAC_OUT=4.
- RND=0 -> MAC_OUT=3.
REQ-044 LEN=3 with 2-cycle in_valid gaps -> same result as gapless; in_valid during DRAIN is not accepted.
REQ-045 MAC_ACC_CLEAR after 2 of 4 elements -> busy=0 next cycle, no out_valid; the following burst gives the correct result.
REQ-046 Rejections and reset:
- start with LEN=0 -> busy stays 0.
- start while busy -> ignored.
- acc_ff_rstn low mid-burst -> all outputs 0, no strobe.
